// File: rtl/main_mem_arbiter.sv
// Main-domain arbiter: drains the cache write-back FIFO to memory and fills program/data lines.
// Optional watchdog on the memory handshake is compiled in with `define MAIN_ARB_TIMEOUT_EN.
module main_mem_arbiter #(
    parameter int unsigned LINE_WORDS     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_req_f_prog,
    input  logic [20:0]  req_addr_f_prog,
    input  logic         is_req_f_data,
    input  logic [20:0]  req_addr_f_data,
    input  logic         prog_line_full,
    input  logic         data_line_full,
    input  logic         fifo_empty,
    input  logic [31:0]  write_back_addr,
    input  logic [31:0]  write_back_data,
    output logic         is_write_t_main,
    output logic         is_write_prog_line,
    output logic         is_write_data_line,
    output logic [511:0] read_main_prog_data,
    output logic [511:0] read_main_data_data,
    output logic [6:0]   read_main_prog_addr,
    output logic [6:0]   read_main_data_addr,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack,
    output logic         mem_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_DELIVER
`ifdef MAIN_ARB_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    if (LINE_WORDS != 16 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("main_mem_arbiter: LINE_WORDS must be 16 and TIMEOUT_CYCLES at least 1");
    end

    state_t         state_q, state_d;
    logic [3:0]     word_q, word_d;
    logic           rr_q, rr_d;
    logic           ch_q, ch_d;
    logic [20:0]    addr_q, addr_d;
    logic [511:0]   line_q, line_d;
    logic [511:0]   prog_line_q, prog_line_d, data_line_q, data_line_d;
    logic [6:0]     prog_idx_q, prog_idx_d, data_idx_q, data_idx_d;
    logic           served_prog_q, served_prog_d, served_data_q, served_data_d;
    logic [20:0]    served_prog_addr_q, served_prog_addr_d;
    logic [20:0]    served_data_addr_q, served_data_addr_d;
    logic           elig_prog, elig_data, pick_data;

`ifdef MAIN_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    assign mem_error = err_q;
`else
    assign mem_error = 1'b0;
`endif

    assign elig_prog = is_req_f_prog && !served_prog_q && !prog_line_full;
    assign elig_data = is_req_f_data && !served_data_q && !data_line_full;
    assign pick_data = elig_data && (!elig_prog || rr_q);

    assign read_main_prog_data = prog_line_q;
    assign read_main_data_data = data_line_q;
    assign read_main_prog_addr = prog_idx_q;
    assign read_main_data_addr = data_idx_q;

    always_comb begin
        state_d            = state_q;
        word_d             = word_q;
        rr_d               = rr_q;
        ch_d               = ch_q;
        addr_d             = addr_q;
        line_d             = line_q;
        prog_line_d        = prog_line_q;
        data_line_d        = data_line_q;
        prog_idx_d         = prog_idx_q;
        data_idx_d         = data_idx_q;
        served_prog_d      = served_prog_q;
        served_data_d      = served_data_q;
        served_prog_addr_d = served_prog_addr_q;
        served_data_addr_d = served_data_addr_q;
        is_write_t_main    = 1'b0;
        is_write_prog_line = 1'b0;
        is_write_data_line = 1'b0;
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        mem_addr           = '0;
        mem_wdata          = '0;

        // A served line stays blocked only while the same line is still being requested.
        if (!is_req_f_prog || req_addr_f_prog != served_prog_addr_q) served_prog_d = 1'b0;
        if (!is_req_f_data || req_addr_f_data != served_data_addr_q) served_data_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_WB;
                end else if (elig_prog || elig_data) begin
                    state_d = S_FILL;
                    ch_d    = pick_data;
                    addr_d  = pick_data ? req_addr_f_data : req_addr_f_prog;
                    word_d  = '0;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = write_back_addr;
                mem_wdata = write_back_data;
                if (mem_ack) begin
                    is_write_t_main = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {5'b0, addr_q, word_q, 2'b00};
                if (mem_ack) begin
                    line_d[{word_q, 5'd0} +: 32] = mem_rdata;
                    word_d = word_q + 4'd1;
                    // Payload is loaded on the final ack so it is already valid during the push pulse.
                    if (word_q == 4'(LINE_WORDS - 1)) begin
                        state_d = S_DELIVER;
                        if (ch_q) begin
                            data_line_d = line_d;
                            data_idx_d  = addr_q[6:0];
                        end else begin
                            prog_line_d = line_d;
                            prog_idx_d  = addr_q[6:0];
                        end
                    end
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
                rr_d    = !rr_q;
                if (ch_q) begin
                    is_write_data_line = 1'b1;
                    served_data_d      = 1'b1;
                    served_data_addr_d = addr_q;
                end else begin
                    is_write_prog_line = 1'b1;
                    served_prog_d      = 1'b1;
                    served_prog_addr_d = addr_q;
                end
            end
`ifdef MAIN_ARB_TIMEOUT_EN
            S_ERR: state_d = S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef MAIN_ARB_TIMEOUT_EN
        tmo_d = '0;
        err_d = err_q;
        if (mem_req && !mem_ack) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= S_IDLE;
            word_q             <= '0;
            rr_q               <= 1'b0;
            ch_q               <= 1'b0;
            addr_q             <= '0;
            line_q             <= '0;
            prog_line_q        <= '0;
            data_line_q        <= '0;
            prog_idx_q         <= '0;
            data_idx_q         <= '0;
            served_prog_q      <= 1'b0;
            served_data_q      <= 1'b0;
            served_prog_addr_q <= '0;
            served_data_addr_q <= '0;
`ifdef MAIN_ARB_TIMEOUT_EN
            tmo_q              <= '0;
            err_q              <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            word_q             <= word_d;
            rr_q               <= rr_d;
            ch_q               <= ch_d;
            addr_q             <= addr_d;
            line_q             <= line_d;
            prog_line_q        <= prog_line_d;
            data_line_q        <= data_line_d;
            prog_idx_q         <= prog_idx_d;
            data_idx_q         <= data_idx_d;
            served_prog_q      <= served_prog_d;
            served_data_q      <= served_data_d;
            served_prog_addr_q <= served_prog_addr_d;
            served_data_addr_q <= served_data_addr_d;
`ifdef MAIN_ARB_TIMEOUT_EN
            tmo_q              <= tmo_d;
            err_q              <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter: a memory responder plus a monitor that checks writes,
// fill addresses and delivered lines against expectations queued by the scenario tasks.
module tb_main_mem_arbiter;

    localparam int K_WB = 0, K_PROG = 1, K_DATA = 2;

    typedef struct {
        int          kind;
        logic [20:0] line;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         is_req_f_prog, is_req_f_data, prog_line_full, data_line_full, fifo_empty;
    logic [20:0]  req_addr_f_prog, req_addr_f_data;
    logic [31:0]  write_back_addr, write_back_data;
    logic         is_write_t_main, is_write_prog_line, is_write_data_line;
    logic [511:0] read_main_prog_data, read_main_data_data;
    logic [6:0]   read_main_prog_addr, read_main_data_addr;
    logic         mem_req, mem_we, mem_error;
    logic [31:0]  mem_addr, mem_wdata;
    logic [31:0]  mem_rdata = '0;
    logic         mem_ack = 1'b0;

    int   checks = 0, errors = 0;
    int   lat = 1;
    bit   no_ack = 1'b0;
    int   wait_cnt = 0;
    int   lines_seen = 0, pops_seen = 0, acks_seen = 0, rd_i = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    main_mem_arbiter #(.LINE_WORDS(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .is_req_f_prog(is_req_f_prog), .req_addr_f_prog(req_addr_f_prog),
        .is_req_f_data(is_req_f_data), .req_addr_f_data(req_addr_f_data),
        .prog_line_full(prog_line_full), .data_line_full(data_line_full),
        .fifo_empty(fifo_empty), .write_back_addr(write_back_addr), .write_back_data(write_back_data),
        .is_write_t_main(is_write_t_main), .is_write_prog_line(is_write_prog_line),
        .is_write_data_line(is_write_data_line),
        .read_main_prog_data(read_main_prog_data), .read_main_data_data(read_main_data_data),
        .read_main_prog_addr(read_main_prog_addr), .read_main_data_addr(read_main_data_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_error(mem_error)
    );

    function automatic logic [31:0] mw(input logic [20:0] line, input logic [3:0] i);
        return 32'h1000_0000 + (({11'd0, line} - 32'h85) << 8) + {28'd0, i};
    endfunction

    function automatic logic [511:0] exp_line(input logic [20:0] line);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = mw(line, 4'(i));
        return l;
    endfunction

    // Memory responder: acks a request after `lat` cycles, one-cycle pulse.
    always @(negedge clk) begin
        if (!reset) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && !no_ack) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                wait_cnt = 0;
                mem_ack = 1'b1;
                mem_rdata = mem_we ? 32'h0 : mw(mem_addr[26:6], mem_addr[5:2]);
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: compares every memory completion and line push with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            rd_i = 0;
        end else begin
            if (int'(is_write_t_main) + int'(is_write_prog_line) + int'(is_write_data_line) > 1) begin
                errors++;
                $display("FAIL one_pulse: pop=%b prog=%b data=%b required at most one", is_write_t_main, is_write_prog_line, is_write_data_line);
            end
            if (mem_ack && mem_we) begin
                acks_seen++;
                checks++;
                if (sb.size() == 0 || sb[0].kind != K_WB) begin
                    errors++;
                    $display("FAIL wb_unexpected: write to %h while no write-back expected", mem_addr);
                end else begin
                    e = sb.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data || is_write_t_main !== 1'b1) begin
                        errors++;
                        $display("FAIL wb_write: addr=%h data=%h pop=%b required addr=%h data=%h pop=1", mem_addr, mem_wdata, is_write_t_main, e.addr, e.data);
                    end
                    pops_seen++;
                end
            end else if (is_write_t_main) begin
                errors++;
                $display("FAIL stray_pop: is_write_t_main=1 without a write ack");
            end
            if (mem_ack && !mem_we) begin
                acks_seen++;
                checks++;
                if (sb.size() == 0 || sb[0].kind == K_WB) begin
                    errors++;
                    $display("FAIL fill_unexpected: read of %h while no fill expected", mem_addr);
                end else if (mem_addr !== {5'b0, sb[0].line, 4'(rd_i), 2'b00}) begin
                    errors++;
                    $display("FAIL fill_addr: got %h required %h", mem_addr, {5'b0, sb[0].line, 4'(rd_i), 2'b00});
                end
                rd_i++;
            end
            if (is_write_prog_line || is_write_data_line) begin
                lines_seen++;
                rd_i = 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL line_unexpected: prog=%b data=%b with nothing expected", is_write_prog_line, is_write_data_line);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != (is_write_data_line ? K_DATA : K_PROG)) begin
                        errors++;
                        $display("FAIL line_channel: got data=%b required kind %0d", is_write_data_line, e.kind);
                    end else if (is_write_prog_line && (read_main_prog_addr !== e.line[6:0] || read_main_prog_data !== exp_line(e.line))) begin
                        errors++;
                        $display("FAIL prog_line: idx=%h data=%h required idx=%h data=%h", read_main_prog_addr, read_main_prog_data, e.line[6:0], exp_line(e.line));
                    end else if (is_write_data_line && (read_main_data_addr !== e.line[6:0] || read_main_data_data !== exp_line(e.line))) begin
                        errors++;
                        $display("FAIL data_line: idx=%h data=%h required idx=%h data=%h", read_main_data_addr, read_main_data_data, e.line[6:0], exp_line(e.line));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input int kind, input logic [20:0] line, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.line = line; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #2; n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected events left after %0d cycles, required 0", name, sb.size(), n);
        end
    endtask

    task automatic wait_pop(input int budget, output int n);
        int p0 = pops_seen;
        n = 0;
        while (pops_seen == p0 && n < budget) begin
            @(negedge clk); #2; n++;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({mem_req, mem_we, is_write_t_main, is_write_prog_line, is_write_data_line, mem_error} !== 6'b0) begin
            errors++;
            $display("FAIL %s_ctrl: req/we/pop/prog/data/err=%b required 000000", name,
                     {mem_req, mem_we, is_write_t_main, is_write_prog_line, is_write_data_line, mem_error});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL %s_bus: addr=%h wdata=%h required 0", name, mem_addr, mem_wdata);
        end
        checks++;
        if (read_main_prog_data !== '0 || read_main_data_data !== '0 || read_main_prog_addr !== 7'h0 || read_main_data_addr !== 7'h0) begin
            errors++;
            $display("FAIL %s_payload: prog_idx=%h data_idx=%h payloads nonzero=%b required all 0", name,
                     read_main_prog_addr, read_main_data_addr, (read_main_prog_data | read_main_data_data) != '0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        {is_req_f_prog, is_req_f_data, prog_line_full, data_line_full} = '0;
        fifo_empty = 1'b1;
        req_addr_f_prog = '0; req_addr_f_data = '0;
        write_back_addr = '0; write_back_data = '0;
        repeat (3) @(negedge clk);
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #2;
        check_idle_outputs("post_reset");
    endtask

    task automatic test_priority;
        int n, l0;
        lat = 2;
        @(negedge clk);
        write_back_addr = 32'h0000_2000; write_back_data = 32'h1234_5678; fifo_empty = 1'b0;
        req_addr_f_prog = 21'h1A3; is_req_f_prog = 1'b1;
        req_addr_f_data = 21'h0C7; is_req_f_data = 1'b1;
        push_exp(K_WB, '0, 32'h0000_2000, 32'h1234_5678);
        push_exp(K_PROG, 21'h1A3, '0, '0);
        push_exp(K_DATA, 21'h0C7, '0, '0);
        wait_pop(50, n);
        @(posedge clk); #1;
        fifo_empty = 1'b1;
        wait_drain(400, "priority");
        l0 = lines_seen;
        repeat (40) @(negedge clk);
        #2;
        checks++;
        if (lines_seen !== l0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL priority_no_refill: extra lines=%0d mem_req=%b required 0 and 0", lines_seen - l0, mem_req);
        end
        is_req_f_prog = 1'b0; is_req_f_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_wb;
        int n;
        lat = 3;
        @(negedge clk);
        write_back_addr = 32'h0000_1040; write_back_data = 32'hDEAD_BEEF; fifo_empty = 1'b0;
        push_exp(K_WB, '0, 32'h0000_1040, 32'hDEAD_BEEF);
        wait_pop(50, n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL wb_latency: pop seen after %0d cycles required 3", n);
        end
        @(posedge clk); #1;
        fifo_empty = 1'b1;
        @(negedge clk); #2;
        checks++;
        if (mem_req !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL wb_return_idle: mem_req=%b pending=%0d required 0 and 0", mem_req, sb.size());
        end
    endtask

    task automatic test_prog_fill;
        int a0, l0;
        logic [31:0] w;
        lat = 1;
        a0 = acks_seen;
        @(negedge clk);
        req_addr_f_prog = 21'h00085; is_req_f_prog = 1'b1;
        push_exp(K_PROG, 21'h00085, '0, '0);
        wait_drain(200, "prog_fill");
        checks++;
        if (acks_seen - a0 !== 16) begin
            errors++;
            $display("FAIL prog_fill_words: got %0d acks required 16", acks_seen - a0);
        end
        checks++;
        if (read_main_prog_addr !== 7'h05) begin
            errors++;
            $display("FAIL prog_fill_idx: got %h required 05", read_main_prog_addr);
        end
        w = read_main_prog_data[31:0];
        checks++;
        if (w !== 32'h1000_0000) begin
            errors++;
            $display("FAIL prog_fill_word0: got %h required 10000000", w);
        end
        w = read_main_prog_data[511:480];
        checks++;
        if (w !== 32'h1000_000F) begin
            errors++;
            $display("FAIL prog_fill_word15: got %h required 1000000f", w);
        end
        l0 = lines_seen;
        repeat (30) @(negedge clk);
        checks++;
        if (lines_seen !== l0) begin
            errors++;
            $display("FAIL prog_fill_held: got %0d extra lines required 0", lines_seen - l0);
        end
        is_req_f_prog = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_fifo;
        int l0;
        lat = 1;
        @(negedge clk);
        prog_line_full = 1'b1;
        req_addr_f_prog = 21'h00033; is_req_f_prog = 1'b1;
        req_addr_f_data = 21'h00144; is_req_f_data = 1'b1;
        push_exp(K_DATA, 21'h00144, '0, '0);
        wait_drain(200, "full_data");
        l0 = lines_seen;
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (lines_seen !== l0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_prog_blocked: extra lines=%0d mem_req=%b required 0 and 0", lines_seen - l0, mem_req);
        end
        push_exp(K_PROG, 21'h00033, '0, '0);
        prog_line_full = 1'b0;
        wait_drain(200, "full_release");
        checks++;
        if (read_main_data_data !== exp_line(21'h00144) || read_main_data_addr !== 7'h44) begin
            errors++;
            $display("FAIL data_payload_hold: idx=%h required 44, payload held=%b required 1",
                     read_main_data_addr, read_main_data_data === exp_line(21'h00144));
        end
        is_req_f_prog = 1'b0; is_req_f_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill;
        int a0, l0, n = 0;
        lat = 1;
        @(negedge clk);
        a0 = acks_seen;
        req_addr_f_prog = 21'h000F0; is_req_f_prog = 1'b1;
        push_exp(K_PROG, 21'h000F0, '0, '0);
        while (acks_seen - a0 < 5 && n < 100) begin
            @(negedge clk); #2; n++;
        end
        checks++;
        if (acks_seen - a0 !== 5) begin
            errors++;
            $display("FAIL mid_fill_acks: got %0d acks required 5", acks_seen - a0);
        end
        @(posedge clk); #2;
        l0 = lines_seen;
        reset = 1'b0;
        #1;
        check_idle_outputs("mid_fill_reset");
        repeat (3) @(negedge clk);
        checks++;
        if (lines_seen !== l0) begin
            errors++;
            $display("FAIL mid_fill_no_push: got %0d pushes during reset required 0", lines_seen - l0);
        end
        reset = 1'b1;
        wait_drain(200, "mid_fill_refill");
        is_req_f_prog = 1'b0;
        @(negedge clk);
    endtask

`ifdef MAIN_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int hi = 0, p0;
        p0 = pops_seen;
        no_ack = 1'b1;
        @(negedge clk);
        write_back_addr = 32'h0000_3000; write_back_data = 32'h5555_AAAA; fifo_empty = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #2;
            if (mem_req) hi++;
        end
        checks++;
        if (hi !== 8 || mem_req !== 1'b0 || mem_error !== 1'b1 || pops_seen !== p0) begin
            errors++;
            $display("FAIL timeout: req cycles=%0d mem_req=%b mem_error=%b pops=%0d required 8,0,1,0", hi, mem_req, mem_error, pops_seen - p0);
        end
        reset = 1'b0;
        fifo_empty = 1'b1;
        no_ack = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (mem_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reset: mem_error=%b required 0", mem_error);
        end
        reset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_single_wb();
        test_prog_fill();
        test_full_fifo();
        test_reset_mid_fill();
`ifdef MAIN_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
